// File: rtl/dimension_sequencer.sv
// Sequences the X then Y sub-pixel filter passes of a motion vector over one
// shared filter datapath, skipping zero-fraction dimensions, and presents the result pair.
module dimension_sequencer #(
   parameter int RES_WIDTH = 16
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        MV_VALID,
   output logic                        MV_READY,
   input  logic signed [3:0]           MV_X_FRAC,
   input  logic signed [3:0]           MV_Y_FRAC,
   output logic                        SELECT,
   output logic signed [3:0]           FRAC_OUT,
   output logic                        FRAC_VALID,
   input  logic                        FILT_DONE,
   input  logic signed [RES_WIDTH-1:0] FILT_RESULT,
   output logic                        RES_VALID,
   input  logic                        RES_READY,
   output logic signed [RES_WIDTH-1:0] RES_X,
   output logic signed [RES_WIDTH-1:0] RES_Y,
   output logic                        RES_X_SKIP,
   output logic                        RES_Y_SKIP,
   output logic [2:0]                  STATE
);

   // MV handshake: a pair transfers on a rising edge where MV_VALID && MV_READY.
   // Result handshake: the pair transfers on a rising edge where RES_VALID && RES_READY.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE_X = 3'd1,
      WAIT_X  = 3'd2,
      ISSUE_Y = 3'd3,
      WAIT_Y  = 3'd4,
      OUT     = 3'd5
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic signed [3:0] frac_x;
   logic signed [3:0] frac_y;
   logic              accept;

   assign accept = MV_VALID && MV_READY;
   assign STATE  = state;

   always_comb begin
      state_nxt  = state;
      MV_READY   = 1'b0;
      SELECT     = 1'b0;
      FRAC_OUT   = 4'sd0;
      FRAC_VALID = 1'b0;
      RES_VALID  = 1'b0;
      case (state)
         IDLE: begin
            MV_READY = 1'b1;
            if (MV_VALID) begin
               if (MV_X_FRAC != 4'sd0)      state_nxt = ISSUE_X;
               else if (MV_Y_FRAC != 4'sd0) state_nxt = ISSUE_Y;
               else                         state_nxt = OUT;
            end
         end
         ISSUE_X: begin
            SELECT     = 1'b1;
            FRAC_OUT   = frac_x;
            FRAC_VALID = 1'b1;
            state_nxt  = WAIT_X;
         end
         WAIT_X: begin
            SELECT = 1'b1;
            if (FILT_DONE) state_nxt = (frac_y != 4'sd0) ? ISSUE_Y : OUT;
         end
         ISSUE_Y: begin
            FRAC_OUT   = frac_y;
            FRAC_VALID = 1'b1;
            state_nxt  = WAIT_Y;
         end
         WAIT_Y: begin
            if (FILT_DONE) state_nxt = OUT;
         end
         OUT: begin
            RES_VALID = 1'b1;
            if (RES_READY) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         frac_x     <= 4'sd0;
         frac_y     <= 4'sd0;
         RES_X      <= '0;
         RES_Y      <= '0;
         RES_X_SKIP <= 1'b0;
         RES_Y_SKIP <= 1'b0;
      end else begin
         state <= state_nxt;
         // Results are cleared on accept so a skipped dimension reads back as zero.
         if (accept) begin
            frac_x     <= MV_X_FRAC;
            frac_y     <= MV_Y_FRAC;
            RES_X      <= '0;
            RES_Y      <= '0;
            RES_X_SKIP <= (MV_X_FRAC == 4'sd0);
            RES_Y_SKIP <= (MV_Y_FRAC == 4'sd0);
         end
         if (state == WAIT_X && FILT_DONE) RES_X <= FILT_RESULT;
         if (state == WAIT_Y && FILT_DONE) RES_Y <= FILT_RESULT;
      end
   end

endmodule

// File: doc/dimension_sequencer.md
DIMENSION_SEQUENCER -- requirements
Module: dimension_sequencer

Interface
REQ-001 SHALL have parameter RES_WIDTH, default 16, giving the signed width of filter results.
REQ-002 SHALL have port CLK  input  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-004 SHALL have port MV_VALID  input  1  a motion-vector fraction pair is offered.
REQ-005 SHALL have port MV_READY  output  1  the block accepts a pair this cycle.
REQ-006 SHALL have port MV_X_FRAC  input  signed 4  MV_X LSB fraction.
REQ-007 SHALL have port MV_Y_FRAC  input  signed 4  MV_Y LSB fraction.
REQ-008 SHALL have port SELECT  output  1  dimension select for the shared filter datapath: 0 = Y, 1 = X.
REQ-009 SHALL have port FRAC_OUT  output  signed 4  fraction issued to the filter: X when SELECT=1, Y when SELECT=0.
REQ-010 SHALL have port FRAC_VALID  output  1  one-cycle strobe marking an issued FRAC_OUT/SELECT.
REQ-011 SHALL have port FILT_DONE  input  1  filter result available on FILT_RESULT.
REQ-012 SHALL have port FILT_RESULT  input  signed RES_WIDTH  filter result.
REQ-013 SHALL have port RES_VALID  output  1  result pair is valid.
REQ-014 SHALL have port RES_READY  input  1  consumer accepts the result pair.
REQ-015 SHALL have ports RES_X and RES_Y  output  signed RES_WIDTH  per-dimension results.
REQ-016 SHALL have ports RES_X_SKIP and RES_Y_SKIP  output  1  the dimension had zero fraction and was not filtered.

Function
REQ-017 SHALL implement the FSM states IDLE, ISSUE_X, WAIT_X, ISSUE_Y, WAIT_Y and OUT.
REQ-018 SHALL assert MV_READY only in IDLE.
REQ-019 SHALL capture both fractions on MV_VALID&MV_READY and leave IDLE on the next edge.
REQ-020 SHALL order passes X first, then Y.
REQ-021 SHALL handle a zero fraction (4'sb0000) by skipping that pass: set the SKIP flag and load 0 into the RES register.
REQ-022 SHALL make the following transitions out of IDLE on accept:
- X frac nonzero -> ISSUE_X;
- else Y frac nonzero -> ISSUE_Y;
- else -> OUT.
REQ-023 SHALL, in ISSUE_X/ISSUE_Y, hold FRAC_VALID=1 for exactly one cycle with SELECT=1/0 and FRAC_OUT equal to the captured X/Y fraction, then move to WAIT_X/WAIT_Y.
REQ-024 SHALL sample FILT_DONE only in WAIT_X/WAIT_Y; FILT_DONE in any other state is ignored.
REQ-025 SHALL, in WAIT_X with FILT_DONE=1, capture FILT_RESULT into RES_X, then go to ISSUE_Y if the Y frac is nonzero, else OUT.
REQ-026 SHALL, in WAIT_Y with FILT_DONE=1, capture FILT_RESULT into RES_Y and go to OUT.
REQ-027 SHALL have no timeout: WAIT states hold indefinitely.
REQ-028 SHALL, in OUT, assert RES_VALID and hold RES_X, RES_Y and the SKIP flags stable until RES_READY=1, then return to IDLE on that edge.
REQ-029 SHALL keep RES_VALID asserted from OUT entry until the RES_READY handshake.
REQ-030 SHALL hold SELECT stable through each WAIT state at the value of the pass in flight, and drive SELECT=0 in IDLE and OUT.
REQ-031 SHALL set FRAC_OUT to 0 whenever FRAC_VALID=0.
REQ-032 SHALL meet these latencies (accept at edge t):
- FRAC_VALID for the first pass at cycle t+1;
- both fractions zero: RES_VALID at cycle t+1;
- otherwise RES_VALID one cycle after the last accepted FILT_DONE.
REQ-033 SHALL accept no new MV until the OUT handshake completes; back-to-back MVs therefore spend at least one IDLE cycle between them.
REQ-034 SHALL store results without arithmetic, truncation or sign alteration.

Reset
REQ-035 SHALL, on RST=1 at an edge, enter IDLE from any state, including mid-pass.
REQ-036 SHALL drive these reset values: MV_READY=1 after reset, FRAC_VALID=0, RES_VALID=0, SELECT=0, FRAC_OUT=0, RES_X=0, RES_Y=0, RES_X_SKIP=0, RES_Y_SKIP=0.
REQ-037 SHALL give RST priority over every other input in the same cycle, including MV_VALID, FILT_DONE and RES_READY.

Verification
REQ-038 SHALL verify the full two-pass case: X=3, Y=-2, FILT_DONE 4 cycles after each strobe, results 100 then -50 -> strobes SELECT=1/FRAC_OUT=3, then SELECT=0/FRAC_OUT=-2; RES_X=100, RES_Y=-50, both SKIP=0.
REQ-039 SHALL verify the both-zero case: X=0, Y=0 -> no FRAC_VALID; RES_VALID at t+1; RES_X=RES_Y=0; both SKIP=1.
REQ-040 SHALL verify the single-pass case: X=0, Y=5, result 7 -> single strobe SELECT=0/FRAC_OUT=5; RES_X_SKIP=1, RES_Y=7.
REQ-041 SHALL verify stray-done and backpressure: FILT_DONE pulsed during IDLE/ISSUE and RES_READY held 0 for 6 cycles -> stray DONE ignored; RES_VALID and data stable for all 6 cycles; IDLE on the first RES_READY=1 edge.
REQ-042 SHALL verify reset mid-operation: RST asserted in WAIT_X -> next cycle all outputs at reset values, MV_READY=1; a late FILT_DONE is ignored.
